// File: rtl/uart_rx_frame.sv
// ---------------------------------------------------------------------------
// uart_rx_frame
//
// Oversampling UART receiver. Turns the asynchronous serial line rx_in into
// parallel bytes for the downstream controller. Each bit is sampled three
// times around its centre and a 2-of-3 majority vote sets its value. Parity
// (optional, even/odd) and the stop bit are checked. A frame with any error
// is flagged by a pulse and is never presented as valid.
//
// Ports
//   clk         oversampling clock (baud rate x prescale)
//   rst         asynchronous reset, active low
//   rx_in       serial line, idle high, asynchronous to clk
//   prescale    oversampling ratio: 8, 16 or 32 (any other value acts as 8)
//   par_en      1 = a parity bit follows the data bits
//   par_typ     0 = even parity, 1 = odd parity
//   rx_p_data   last correctly received byte
//   rx_d_valid  one-cycle pulse: a new good byte is on rx_p_data
//   par_err     one-cycle pulse: parity mismatch on the frame just ended
//   stp_err     one-cycle pulse: stop bit sampled 0 on the frame just ended
// ---------------------------------------------------------------------------
module uart_rx_frame #(
    parameter int data_width     = 8,
    parameter int prescale_width = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rx_in,
    input  logic [prescale_width-1:0] prescale,
    input  logic                      par_en,
    input  logic                      par_typ,
    output logic [data_width-1:0]     rx_p_data,
    output logic                      rx_d_valid,
    output logic                      par_err,
    output logic                      stp_err
);

    localparam int BC_W = $clog2(data_width + 1);
    localparam logic [BC_W-1:0]           LAST_BIT = BC_W'(data_width - 1);
    localparam logic [prescale_width-1:0] ONE      = prescale_width'(1);
    localparam logic [prescale_width-1:0] P8       = prescale_width'(8);
    localparam logic [prescale_width-1:0] P16      = prescale_width'(16);
    localparam logic [prescale_width-1:0] P32      = prescale_width'(32);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                    state_q,      state_d;
    logic                      sync1_q,      sync1_d;
    logic                      sync2_q,      sync2_d;
    logic [prescale_width-1:0] edge_cnt_q,   edge_cnt_d;
    logic [BC_W-1:0]           bit_cnt_q,    bit_cnt_d;
    logic [prescale_width-1:0] p_q,          p_d;
    logic                      par_en_q,     par_en_d;
    logic                      par_typ_q,    par_typ_d;
    logic [1:0]                samp_q,       samp_d;
    logic                      bit_q,        bit_d;
    logic [data_width-1:0]     shift_q,      shift_d;
    logic                      par_bad_q,    par_bad_d;
    logic                      brk_q,        brk_d;
    logic [data_width-1:0]     rx_p_data_q,  rx_p_data_d;
    logic                      rx_d_valid_q, rx_d_valid_d;
    logic                      par_err_q,    par_err_d;
    logic                      stp_err_q,    stp_err_d;

    logic                      rxs;
    logic [prescale_width-1:0] half;
    logic                      at_s0, at_s1, at_s2, at_last;
    logic                      maj;

    assign rxs = sync2_q;

    always_comb begin
        sync1_d      = rx_in;
        sync2_d      = sync1_q;
        state_d      = state_q;
        edge_cnt_d   = edge_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        p_d          = p_q;
        par_en_d     = par_en_q;
        par_typ_d    = par_typ_q;
        samp_d       = samp_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        par_bad_d    = par_bad_q;
        brk_d        = brk_q;
        rx_p_data_d  = rx_p_data_q;
        rx_d_valid_d = 1'b0;
        par_err_d    = 1'b0;
        stp_err_d    = 1'b0;

        half    = p_q >> 1;
        at_s0   = (edge_cnt_q == half - ONE);
        at_s1   = (edge_cnt_q == half);
        at_s2   = (edge_cnt_q == half + ONE);
        at_last = (edge_cnt_q == p_q - ONE);
        // Third sample is the live rxs on the cycle the vote is taken.
        maj     = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxs) | (samp_q[1] & rxs);

        if (state_q != IDLE) begin
            edge_cnt_d = at_last ? '0 : edge_cnt_q + ONE;
            if (at_s0) samp_d[0] = rxs;
            if (at_s1) samp_d[1] = rxs;
            if (at_s2) bit_d     = maj;
        end

        case (state_q)
            IDLE: begin
                edge_cnt_d = '0;
                bit_cnt_d  = '0;
                if (brk_q) begin
                    // After a stop error the line must go high before a
                    // falling edge can count as a new start bit.
                    if (rxs) brk_d = 1'b0;
                end else if (!rxs) begin
                    // This cycle is edge 0 of the start bit.
                    state_d    = START;
                    edge_cnt_d = ONE;
                    par_en_d   = par_en;
                    par_typ_d  = par_typ;
                    par_bad_d  = 1'b0;
                    if (prescale == P8 || prescale == P16 || prescale == P32)
                        p_d = prescale;
                    else
                        p_d = P8;
                end
            end
            START: begin
                if (at_last) state_d = bit_q ? IDLE : DATA;
            end
            DATA: begin
                if (at_s2) shift_d = {maj, shift_q[data_width-1:1]};
                if (at_last) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (at_s2) par_bad_d = maj ^ (^shift_q) ^ par_typ_q;
                if (at_last) state_d = STOP;
            end
            STOP: begin
                if (at_last) begin
                    state_d   = IDLE;
                    par_err_d = par_bad_q;
                    if (!bit_q) begin
                        stp_err_d = 1'b1;
                        brk_d     = 1'b1;
                    end
                    if (bit_q && !par_bad_q) begin
                        rx_d_valid_d = 1'b1;
                        rx_p_data_d  = shift_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            state_q      <= IDLE;
            edge_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            p_q          <= P8;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            samp_q       <= '0;
            bit_q        <= 1'b0;
            shift_q      <= '0;
            par_bad_q    <= 1'b0;
            brk_q        <= 1'b0;
            rx_p_data_q  <= '0;
            rx_d_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            state_q      <= state_d;
            edge_cnt_q   <= edge_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            p_q          <= p_d;
            par_en_q     <= par_en_d;
            par_typ_q    <= par_typ_d;
            samp_q       <= samp_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            par_bad_q    <= par_bad_d;
            brk_q        <= brk_d;
            rx_p_data_q  <= rx_p_data_d;
            rx_d_valid_q <= rx_d_valid_d;
            par_err_q    <= par_err_d;
            stp_err_q    <= stp_err_d;
        end
    end

    assign rx_p_data  = rx_p_data_q;
    assign rx_d_valid = rx_d_valid_q;
    assign par_err    = par_err_q;
    assign stp_err    = stp_err_q;

endmodule
